uart_rx_baud: RTL and testbench

- UART receive path: the receiving end of the serial link whose baud rate is selected by the switch-driven prescaler configuration.
- Samples the asynchronous RX pin, reconstructs 8N1 frames at the selected rate, and presents each byte with a one-cycle valid pulse to the BCD/display logic.
- Uses the same baud-select encoding as the transmit side, so both ends share `Switches[0]` (enable) and `Switches[2:1]` (rate).

---
 rtl/uart_rx_baud.sv | 149 ++++++++++++++
 tb/tb_uart_rx_baud.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_baud.sv
// ============================================================================
// Module   : uart_rx_baud
// Brief    : 8N1 UART receiver with switch-selected baud rate and RX synchronizer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_baud #(
  parameter int CLK_FREQ    = 50000000,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 src_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           baud_sel,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = 13;
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] C_BIT_9600    = CNT_W'(CLK_FREQ / 9600);
  localparam logic [CNT_W-1:0] C_BIT_57600   = CNT_W'(CLK_FREQ / 57600);
  localparam logic [CNT_W-1:0] C_BIT_115200  = CNT_W'(CLK_FREQ / 115200);
  localparam logic [CNT_W-1:0] C_HALF_9600   = CNT_W'((CLK_FREQ / 9600) / 2);
  localparam logic [CNT_W-1:0] C_HALF_57600  = CNT_W'((CLK_FREQ / 57600) / 2);
  localparam logic [CNT_W-1:0] C_HALF_115200 = CNT_W'((CLK_FREQ / 115200) / 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_prev_q;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [1:0]             rate_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   ferr_q;

  logic                   line;
  logic                   fall;
  logic                   abort;
  logic [CNT_W-1:0]       half_sel;
  logic [CNT_W-1:0]       bit_len;

  assign line  = sync_q[SYNC_STAGES-1];
  assign fall  = line_prev_q & ~line;
  assign abort = ~enable | (baud_sel == 2'b11);

  // Start delay uses the live selection: the rate is latched on this same edge.
  always_comb begin
    case (baud_sel)
      2'b00:   half_sel = C_HALF_9600;
      2'b01:   half_sel = C_HALF_57600;
      default: half_sel = C_HALF_115200;
    endcase
  end

  always_comb begin
    case (rate_q)
      2'b00:   bit_len = C_BIT_9600;
      2'b01:   bit_len = C_BIT_57600;
      default: bit_len = C_BIT_115200;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      sync_q      <= '1;
      line_prev_q <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rate_q      <= 2'b00;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
      line_prev_q <= line;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;

      if (state_q == S_IDLE) begin
        if (enable && (baud_sel != 2'b11) && fall) begin
          rate_q  <= baud_sel;
          cnt_q   <= half_sel - CNT_W'(1);
          state_q <= S_START;
        end
      end else if (abort) begin
        state_q <= S_IDLE;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        case (state_q)
          S_START: begin
            if (!line) begin
              cnt_q   <= bit_len - CNT_W'(1);
              idx_q   <= '0;
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_DATA: begin
            shift_q <= {line, shift_q[DATA_BITS-1:1]};
            cnt_q   <= bit_len - CNT_W'(1);
            if (idx_q == IDX_W'(DATA_BITS - 1)) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          S_STOP: begin
            if (line) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q  <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_baud.sv
// ============================================================================
// Module   : tb_uart_rx_baud
// Brief    : Randomized frame stimulus against a timing-level UART receive model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_baud;

  localparam int CLK_HZ = 50000000;
  localparam int S      = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] baud_sel = 2'b00;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  always #10 clk = ~clk;

  uart_rx_baud #(
    .CLK_FREQ    (CLK_HZ),
    .DATA_BITS   (8),
    .SYNC_STAGES (S)
  ) dut (
    .src_clk    (clk),
    .rst        (rst),
    .enable     (enable),
    .baud_sel   (baud_sel),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  // Model: each accepted frame owns a busy window [lo,hi) and a pulse at hi.
  int         w_lo[$];
  int         w_hi[$];
  int         p_at[$];
  bit         p_fe[$];
  logic [7:0] p_byte[$];
  logic [7:0] m_data = 8'h00;

  int         dv_at[$];
  logic [7:0] dv_data[$];
  int         fe_cnt = 0;
  int         last_k = 0;

  function automatic int bitp(input int r);
    case (r)
      0:       return CLK_HZ / 9600;
      1:       return CLK_HZ / 57600;
      default: return CLK_HZ / 115200;
    endcase
  endfunction

  function automatic int halfp(input int r);
    return bitp(r) / 2;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic cut(input int r);
    foreach (w_hi[i]) if (w_hi[i] > r) w_hi[i] = (w_lo[i] < r) ? r : w_lo[i];
    for (int i = p_at.size() - 1; i >= 0; i--) begin
      if (p_at[i] >= r) begin
        p_at.delete(i);
        p_fe.delete(i);
        p_byte.delete(i);
      end
    end
  endtask

  initial begin
    bit         e_busy;
    bit         e_dv;
    bit         e_fe;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (chk_on) begin
        e_busy = 1'b0;
        e_dv   = 1'b0;
        e_fe   = 1'b0;
        if (rst) m_data = 8'h00;
        foreach (w_lo[i]) if (cyc >= w_lo[i] && cyc < w_hi[i]) e_busy = 1'b1;
        foreach (p_at[i]) begin
          if (p_at[i] == cyc) begin
            if (p_fe[i]) e_fe = 1'b1;
            else begin
              e_dv   = 1'b1;
              m_data = p_byte[i];
            end
          end
        end
        check("busy", busy, e_busy);
        check("data_valid", data_valid, e_dv);
        check("frame_err", frame_err, e_fe);
        check("data_out", data_out, m_data);
        if (data_valid) begin
          dv_at.push_back(cyc);
          dv_data.push_back(data_out);
        end
        if (frame_err) fe_cnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // hook_kind: 1 = drop enable, 2 = switch to 115200, 3 = reset; applied mid-bit hook_bit.
  task automatic send(input logic [7:0] b, input bit stop, input int r_pin,
                      input int stop_len, input int hook_bit, input int hook_kind);
    int bp;
    int k;
    int lat;
    int r;
    bp = bitp(r_pin);
    @(negedge clk);
    rx = 1'b0;
    k = cyc + 1;
    last_k = k;
    if (enable && baud_sel != 2'b11) begin
      r   = int'(baud_sel);
      lat = S + halfp(r) + 9 * bitp(r);
      w_lo.push_back(k + S);
      w_hi.push_back(k + lat);
      p_at.push_back(k + lat);
      p_fe.push_back(!stop);
      p_byte.push_back(b);
    end
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == hook_bit) begin
        repeat (bp / 2) @(negedge clk);
        if (hook_kind == 1) begin
          enable = 1'b0;
          cut(cyc + 1);
          rx = 1'b1;
          repeat (S + 4) @(negedge clk);
          return;
        end else if (hook_kind == 2) begin
          baud_sel = 2'b10;
        end else begin
          rst = 1'b1;
          rx  = 1'b1;
          cut(cyc + 1);
          @(negedge clk);
          check("reset_data_out", data_out, 0);
          check("reset_busy", busy, 0);
          check("reset_data_valid", data_valid, 0);
          rst = 1'b0;
          repeat (S + 4) @(negedge clk);
          return;
        end
        repeat (bp - bp / 2) @(negedge clk);
      end else begin
        repeat (bp) @(negedge clk);
      end
    end
    rx = stop;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic glitch(input int low_len);
    int k;
    @(negedge clk);
    rx = 1'b0;
    k = cyc + 1;
    if (enable && baud_sel != 2'b11) begin
      w_lo.push_back(k + S);
      w_hi.push_back(k + S + halfp(int'(baud_sel)));
    end
    repeat (low_len) @(negedge clk);
    rx = 1'b1;
    repeat (halfp(int'(baud_sel)) + S + 20) @(negedge clk);
  endtask

  function automatic int short_stop(input int r);
    return halfp(r) + S + 4;
  endfunction

  initial begin
    logic [7:0] rb;
    int         ndv;
    int         lat;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    baud_sel = 2'b00;
    idle(10);

    // 9600 frame; rate switch to 115200 during bit 3 must not disturb it.
    send(8'hA5, 1'b1, 0, short_stop(0), 3, 2);
    idle(10);
    check("dv_count_9600", dv_at.size(), 1);
    lat = (dv_at.size() > 0) ? dv_at[$] - last_k : -1;
    check("latency_9600", lat, 2 + 2604 + 9 * 5208);
    check("data_9600", data_out, 8'hA5);
    check("busy_after_9600", busy, 0);

    rb = 8'($urandom);
    send(rb, 1'b1, 2, short_stop(2), -1, 0);
    idle($urandom_range(5, 30));
    check("data_after_rate_change", data_out, rb);

    baud_sel = 2'b00;
    idle(5);
    ndv = dv_at.size();
    glitch(1000);
    check("glitch_no_dv", dv_at.size(), ndv);
    check("glitch_no_fe", fe_cnt, 0);
    check("glitch_busy", busy, 0);

    baud_sel = 2'b10;
    idle(10);
    send(8'h3C, 1'b1, 2, bitp(2) - 1, -1, 0);
    send(8'hC3, 1'b1, 2, short_stop(2), -1, 0);
    idle(10);
    check("b2b_dv_count", dv_at.size(), ndv + 2);
    if (dv_at.size() >= 2) begin
      check("b2b_gap", dv_at[$] - dv_at[dv_at.size() - 2], 4340);
      check("b2b_first", dv_data[dv_data.size() - 2], 8'h3C);
      check("b2b_second", dv_data[$], 8'hC3);
    end

    baud_sel = 2'b01;
    idle($urandom_range(5, 30));
    ndv = dv_at.size();
    send(8'h55, 1'b0, 1, short_stop(1), -1, 0);
    idle(20);
    check("ferr_count", fe_cnt, 1);
    check("ferr_no_dv", dv_at.size(), ndv);
    check("ferr_data_kept", data_out, 8'hC3);

    send(8'hFF, 1'b1, 1, short_stop(1), 4, 1);
    check("abort_busy", busy, 0);
    idle(20);
    enable = 1'b1;
    baud_sel = 2'b11;
    idle(5);
    send(8'($urandom), 1'b1, 2, short_stop(2), -1, 0);
    idle(10);
    check("abort_no_dv", dv_at.size(), ndv);
    check("abort_no_fe", fe_cnt, 1);

    baud_sel = 2'b10;
    idle(10);
    send(8'($urandom), 1'b1, 2, short_stop(2), 3, 3);
    idle(10);
    send(8'h12, 1'b1, 2, short_stop(2), -1, 0);
    idle(10);
    check("post_reset_dv_count", dv_at.size(), ndv + 1);
    check("post_reset_data", data_out, 8'h12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
